// File: rtl/sqvt_wave_gen_pkg.sv
// Shared types and constants for the square-wave sample generator.
// Optional feature macro: SQVT_DEADBAND_EN (adds a per-phase midpoint
// dead band controlled by DeadCnt).
package sqvt_pkg;

  localparam int SQVT_DW     = 12;
  localparam int SQVT_EN_DLY = 2;   // pipeline depth of the voltage path
  localparam int SQVT_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } sqvt_state_e;

  // One waveform configuration: period, high time and the two level codes.
  typedef struct packed {
    logic [SQVT_CNT_W-1:0] p;
    logic [SQVT_CNT_W-1:0] h;
    logic [SQVT_DW-1:0]    vhigh;
    logic [SQVT_DW-1:0]    vlow;
`ifdef SQVT_DEADBAND_EN
    logic [7:0]            dead;
`endif
  } sqvt_cfg_t;

  // Clamp a raw configuration: period of at least 2, high time within period.
  function automatic sqvt_cfg_t sqvt_sanitize(input sqvt_cfg_t raw);
    sqvt_cfg_t c;
    c = raw;
    if (raw.p < SQVT_CNT_W'(2)) c.p = SQVT_CNT_W'(2);
    if (raw.h > c.p) c.h = c.p;
    return c;
  endfunction

`ifdef SQVT_DEADBAND_EN
  // Dead-band cycles for a phase: never longer than the phase itself.
  function automatic logic [7:0] sqvt_dead_len(input logic [7:0] dead,
                                               input logic [SQVT_CNT_W-1:0] len);
    if (len < SQVT_CNT_W'(dead)) return len[7:0];
    return dead;
  endfunction
`endif

endpackage

// File: rtl/sqvt_wave_gen_if.sv
// Configuration bus of the square-wave generator.
// Optional feature macro: SQVT_DEADBAND_EN (adds DeadCnt).
// Handshake: Cfg_Load is a one-cycle valid with no ready; the generator
// accepts every pulse, capturing Period/HighCnt/VHigh/VLow (and DeadCnt)
// on the same rising edge into its pending register.
interface sqvt_wave_gen_if #(
  parameter int CNT_W = 16,
  parameter int DW    = 12
);
  logic             Cfg_Load;
  logic [CNT_W-1:0] Period;
  logic [CNT_W-1:0] HighCnt;
  logic [DW-1:0]    VHigh;
  logic [DW-1:0]    VLow;
`ifdef SQVT_DEADBAND_EN
  logic [7:0]       DeadCnt;

  modport master (output Cfg_Load, Period, HighCnt, VHigh, VLow, DeadCnt);
  modport slave  (input  Cfg_Load, Period, HighCnt, VHigh, VLow, DeadCnt);
`else
  modport master (output Cfg_Load, Period, HighCnt, VHigh, VLow);
  modport slave  (input  Cfg_Load, Period, HighCnt, VHigh, VLow);
`endif
endinterface

// File: rtl/sqvt_en_align.sv
// Fixed-depth delay line with synchronous clear; lines the load strobe up
// with data that has passed through the voltage path pipeline.
module sqvt_en_align
  import sqvt_pkg::*;
#(
  parameter int DEPTH = SQVT_EN_DLY
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr_q, sr_d;

  // Shift the strobe one stage per cycle.
  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = d;
    for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
  end

  // Delay-line register, emptied by clear.
  always_ff @(posedge clk) begin
    if (clr) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/sqvt_wave_gen.sv
// Square-wave sample generator feeding the square-wave voltage path.
// Optional feature macro: SQVT_DEADBAND_EN (midpoint level for the first
// DeadCnt cycles of each phase).
// The FSM state describes the current cycle; Dout/Sync/Busy are registered
// from it, so they trail the state by one cycle. EN trails Dout by two more.
module sqvt_wave_gen
  import sqvt_pkg::*;
#(
  parameter int CNT_W = SQVT_CNT_W,
  parameter int DW    = SQVT_DW
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Run,
  sqvt_wave_gen_if.slave     cfg,
  output logic [DW-1:0]      Dout,
  output logic               EN,
  output logic               Sync,
  output logic               Busy,
  output sqvt_state_e        state_dbg
);

  sqvt_state_e       state_q, state_d, start_state;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  sqvt_cfg_t         pend_q, pend_d, act_q, act_d;
  sqvt_cfg_t         cfg_in, cfg_idle, cfg_wrap, start_cfg;
  logic [SQVT_CNT_W-1:0] start_len, low_len;
  logic              first_q, first_d;
  logic              do_start, go_low, go_idle;
  logic [DW-1:0]     dout_q, dout_d, level;
  logic              sync_q, sync_d;
  logic              busy_q, busy_d;
  logic              chg_q, chg_d;
  logic              rst_seen_q;
`ifdef SQVT_DEADBAND_EN
  logic [7:0]        dead_q, dead_d;
  logic [DW:0]       mid_sum;
`endif

  // Pending register write, and the sanitised copies used for IDLE and for
  // the period boundary (the boundary copy sees a same-cycle load).
  always_comb begin
    cfg_in       = '0;
    cfg_in.p     = cfg.Period;
    cfg_in.h     = cfg.HighCnt;
    cfg_in.vhigh = cfg.VHigh;
    cfg_in.vlow  = cfg.VLow;
`ifdef SQVT_DEADBAND_EN
    cfg_in.dead  = cfg.DeadCnt;
`endif
    pend_d   = cfg.Cfg_Load ? cfg_in : pend_q;
    cfg_idle = sqvt_sanitize(pend_q);
    cfg_wrap = sqvt_sanitize(pend_d);
  end

  // First phase of a new period: HIGH unless the high time is zero.
  always_comb begin
    start_cfg   = (state_q == ST_IDLE) ? cfg_idle : cfg_wrap;
    start_state = (start_cfg.h == '0) ? ST_LOW : ST_HIGH;
    start_len   = (start_cfg.h == '0) ? start_cfg.p : start_cfg.h;
    low_len     = act_q.p - act_q.h;
  end

  // Next-state logic: phase counter reloads on every state entry and the
  // terminal count (zero) ends the phase; Run low overrides everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    act_d    = act_q;
    first_d  = 1'b0;
    do_start = 1'b0;
    go_low   = 1'b0;
    go_idle  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        act_d    = cfg_idle;
        cnt_d    = '0;
        do_start = Run;
      end
      ST_HIGH: begin
        if (!Run) go_idle = 1'b1;
        else if (cnt_q == '0) begin
          // With H == P there is no low phase: the period ends here.
          if (act_q.h == act_q.p) do_start = 1'b1;
          else                    go_low   = 1'b1;
        end
      end
      ST_LOW: begin
        if (!Run)                 go_idle  = 1'b1;
        else if (cnt_q == '0)     do_start = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase
    if (go_low) begin
      state_d = ST_LOW;
      cnt_d   = CNT_W'(low_len - 1'b1);
    end
    if (go_idle) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
    if (do_start) begin
      state_d = start_state;
      cnt_d   = CNT_W'(start_len - 1'b1);
      act_d   = start_cfg;
      first_d = 1'b1;
    end
  end

`ifdef SQVT_DEADBAND_EN
  // Dead-band counter: loaded on each phase entry, counts down to zero.
  always_comb begin
    dead_d = (dead_q != 8'd0) ? dead_q - 8'd1 : 8'd0;
    if (do_start)                           dead_d = sqvt_dead_len(start_cfg.dead, start_len);
    else if (go_low)                        dead_d = sqvt_dead_len(act_q.dead, low_len);
    else if (go_idle || state_q == ST_IDLE) dead_d = 8'd0;
  end
`endif

  // Output stage inputs: level for the current state, Sync on period start,
  // change strobe whenever Dout will take a new value (or just out of reset).
  always_comb begin
    level = (state_q == ST_HIGH) ? act_q.vhigh : act_q.vlow;
`ifdef SQVT_DEADBAND_EN
    mid_sum = {1'b0, act_q.vhigh} + {1'b0, act_q.vlow};
    if (state_q != ST_IDLE && dead_q != 8'd0) level = mid_sum[DW:1];
`endif
    dout_d = level;
    sync_d = first_q;
    busy_d = (state_q != ST_IDLE);
    chg_d  = (dout_d != dout_q) | rst_seen_q;
  end

  // State, configuration and output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pend_q     <= '0;
      act_q      <= '0;
      first_q    <= 1'b0;
      dout_q     <= '0;
      sync_q     <= 1'b0;
      busy_q     <= 1'b0;
      chg_q      <= 1'b0;
      rst_seen_q <= 1'b1;
`ifdef SQVT_DEADBAND_EN
      dead_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      act_q      <= act_d;
      first_q    <= first_d;
      dout_q     <= dout_d;
      sync_q     <= sync_d;
      busy_q     <= busy_d;
      chg_q      <= chg_d;
      rst_seen_q <= 1'b0;
`ifdef SQVT_DEADBAND_EN
      dead_q     <= dead_d;
`endif
    end
  end

  sqvt_en_align #(.DEPTH(SQVT_EN_DLY)) u_en_align (
    .clk (Clock),
    .clr (Reset),
    .d   (chg_q),
    .q   (EN)
  );

  assign Dout      = dout_q;
  assign Sync      = sync_q;
  assign Busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sqvt_wave_gen.sv
// Bench for sqvt_wave_gen: table of configurations with expected period and
// high-time, hand sequences for the corner cases, and random traffic, all
// cross-checked every cycle against a sample-queue reference model.
module tb_sqvt_wave_gen;
  import sqvt_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [11:0] dout;
  logic        en, sync, busy;
  sqvt_state_e st;

  sqvt_wave_gen_if #(.CNT_W(16), .DW(12)) cfg_bus ();

  sqvt_wave_gen #(.CNT_W(16), .DW(12)) dut (
    .Clock     (clk),
    .Reset     (rst),
    .Run       (run),
    .cfg       (cfg_bus),
    .Dout      (dout),
    .EN        (en),
    .Sync      (sync),
    .Busy      (busy),
    .state_dbg (st)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  typedef struct { int p; int h; int vh; int vl; int dc; } mcfg_t;
  mcfg_t       m_pend, m_act;
  logic [12:0] exp_q[$];      // remaining samples of this period: {sync, level}
  bit          m_idle = 1'b1;
  bit          m_after_rst = 1'b0;
  logic [11:0] exp_dout = '0;
  bit          exp_sync, exp_busy, exp_chg, exp_s1, exp_en;

  function automatic mcfg_t san(input mcfg_t r);
    mcfg_t c = r;
    if (c.p < 2) c.p = 2;
    if (c.h > c.p) c.h = c.p;
    return c;
  endfunction

  // Queue up one full period of samples.
  function automatic void fill(input mcfg_t c);
    int lv;
    for (int i = 0; i < c.p; i++) begin
      if (i < c.h) lv = (i < c.dc) ? (c.vh + c.vl) / 2 : c.vh;
      else         lv = ((i - c.h) < c.dc) ? (c.vh + c.vl) / 2 : c.vl;
      exp_q.push_back({(i == 0), lv[11:0]});
    end
  endfunction

  function automatic mcfg_t bus_cfg();
    mcfg_t c;
    c.p  = int'(cfg_bus.Period);
    c.h  = int'(cfg_bus.HighCnt);
    c.vh = int'(cfg_bus.VHigh);
    c.vl = int'(cfg_bus.VLow);
`ifdef SQVT_DEADBAND_EN
    c.dc = int'(cfg_bus.DeadCnt);
`else
    c.dc = 0;
`endif
    return c;
  endfunction

  // Advance the model by one rising edge using the inputs sampled there.
  task automatic model_step();
    logic [11:0] nd;
    bit          ns, nb, nc;
    if (rst) begin
      m_pend = '{0, 0, 0, 0, 0};
      m_act  = '{0, 0, 0, 0, 0};
      exp_q.delete();
      m_idle = 1'b1; m_after_rst = 1'b1;
      exp_dout = '0; exp_sync = 0; exp_busy = 0;
      exp_chg = 0; exp_s1 = 0; exp_en = 0;
      return;
    end
    nd = m_idle ? m_act.vl[11:0] : exp_q[0][11:0];
    ns = m_idle ? 1'b0 : exp_q[0][12];
    nb = !m_idle;
    nc = (nd != exp_dout) || m_after_rst;
    exp_en = exp_s1; exp_s1 = exp_chg; exp_chg = nc;
    exp_dout = nd; exp_sync = ns; exp_busy = nb;
    m_after_rst = 1'b0;
    if (m_idle) begin
      m_act = san(m_pend);
      if (run) begin m_idle = 1'b0; fill(m_act); end
    end else if (!run) begin
      m_idle = 1'b1;
      exp_q.delete();
    end else begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        m_act = san(cfg_bus.Cfg_Load ? bus_cfg() : m_pend);
        fill(m_act);
      end
    end
    if (cfg_bus.Cfg_Load) m_pend = bus_cfg();
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout at %0t", name, $time);
  endtask

  // One clock: model at the rising edge, compare at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("dout", 32'(dout), 32'(exp_dout));
    chk("sync", 32'(sync), 32'(exp_sync));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("en",   32'(en),   32'(exp_en));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cfg(input int p, input int h, input int vh, input int vl, input int dc);
    cfg_bus.Period  = 16'(p);
    cfg_bus.HighCnt = 16'(h);
    cfg_bus.VHigh   = 12'(vh);
    cfg_bus.VLow    = 12'(vl);
`ifdef SQVT_DEADBAND_EN
    cfg_bus.DeadCnt = 8'(dc);
`else
    if (dc != 0) $display("note: dead band not built, DeadCnt %0d ignored", dc);
`endif
  endtask

  task automatic load(input int p, input int h, input int vh, input int vl, input int dc);
    set_cfg(p, h, vh, vl, dc);
    cfg_bus.Cfg_Load = 1'b1;
    tick();
    cfg_bus.Cfg_Load = 1'b0;
  endtask

  task automatic wait_sync(input string name);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (sync === 1'b1) return;
    end
    timeout_fail(name);
  endtask

  // Starting on a Sync cycle, walk to the next Sync; optionally pulse
  // Cfg_Load (with the bus values already set) on cycle load_at.
  task automatic measure(input int load_at, input logic [11:0] vh, input logic [11:0] vm,
                         output int len, output int hi, output int nm);
    len = 0; hi = 0; nm = 0;
    do begin
      if (dout === vh) hi++;
      if (dout === vm) nm++;
      len++;
      cfg_bus.Cfg_Load = (len == load_at);
      tick();
      cfg_bus.Cfg_Load = 1'b0;
    end while (sync !== 1'b1 && len < 100);
    if (len >= 100) timeout_fail("measure");
  endtask

  typedef struct { int p; int h; int exp_len; int exp_hi; } vec_t;
  vec_t vecs[7];

  // ---------------- test ----------------
  initial begin
    int len, hi, nm, r;

    vecs[0] = '{10,  4, 10,  4};
    vecs[1] = '{10,  0, 10,  0};
    vecs[2] = '{10, 12, 10, 10};
    vecs[3] = '{ 1,  1,  2,  1};
    vecs[4] = '{ 0,  5,  2,  2};
    vecs[5] = '{ 7,  7,  7,  7};
    vecs[6] = '{ 3,  2,  3,  2};

    cfg_bus.Cfg_Load = 1'b0;
    set_cfg(0, 0, 0, 0, 0);

    // Reset state and post-reset EN strobe.
    rst = 1'b1;
    tick();
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sync", 32'(sync), 32'h0);
    chk("rst_state", 32'(st), 32'(ST_IDLE));
    rst = 1'b0;
    tick(); chk("rel_en1", 32'(en), 32'h0);
    tick(); chk("rel_en2", 32'(en), 32'h0);
    tick(); chk("rel_en3", 32'(en), 32'h1);

    // Table-driven configurations.
    foreach (vecs[k]) begin
      run = 1'b0;
      tick(); tick();
      load(vecs[k].p, vecs[k].h, 12'hFFF, 12'h000, 0);
      run = 1'b1;
      wait_sync("vec_sync");
      measure(0, 12'hFFF, 12'h800, len, hi, nm);
      chk($sformatf("vec%0d_len", k), 32'(len), 32'(vecs[k].exp_len));
      chk($sformatf("vec%0d_hi", k),  32'(hi),  32'(vecs[k].exp_hi));
    end

    // Mid-period load: current 10-cycle period stays, next is 3+3.
    run = 1'b0; tick(); tick();
    load(10, 4, 12'hFFF, 12'h000, 0);
    run = 1'b1;
    wait_sync("mid_sync");
    set_cfg(6, 3, 12'hFFF, 12'h000, 0);
    measure(3, 12'hFFF, 12'h800, len, hi, nm);
    chk("mid_cur_len", 32'(len), 32'd10);
    chk("mid_cur_hi",  32'(hi),  32'd4);
    measure(0, 12'hFFF, 12'h800, len, hi, nm);
    chk("mid_new_len", 32'(len), 32'd6);
    chk("mid_new_hi",  32'(hi),  32'd3);

    // Run dropped during HIGH, then restarted with a full high phase.
    run = 1'b0;
    tick(); tick();
    chk("stop_dout", 32'(dout), 32'h000);
    chk("stop_busy", 32'(busy), 32'h0);
    run = 1'b1;
    wait_sync("restart_sync");
    measure(0, 12'hFFF, 12'h800, len, hi, nm);
    chk("restart_len", 32'(len), 32'd6);
    chk("restart_hi",  32'(hi),  32'd3);

    // Reset asserted for one cycle in the LOW phase.
    load(10, 4, 12'hABC, 12'h123, 0);
    wait_sync("low_sync");
    while (dout !== 12'h123 && checks < 100000) tick();
    chk("in_low", 32'(dout), 32'h123);
    rst = 1'b1; run = 1'b0;
    tick();
    chk("mrst_dout", 32'(dout), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_sync", 32'(sync), 32'h0);
    chk("mrst_en", 32'(en), 32'h0);
    chk("mrst_state", 32'(st), 32'(ST_IDLE));
    rst = 1'b0;
    tick(); chk("mrel_en1", 32'(en), 32'h0);
    tick(); chk("mrel_en2", 32'(en), 32'h0);
    tick(); chk("mrel_en3", 32'(en), 32'h1);

`ifdef SQVT_DEADBAND_EN
    // Dead band: each phase opens with two midpoint cycles.
    load(10, 4, 12'hFFF, 12'h001, 2);
    run = 1'b1;
    wait_sync("dead_sync");
    measure(0, 12'hFFF, 12'h800, len, hi, nm);
    chk("dead_len", 32'(len), 32'd10);
    chk("dead_hi",  32'(hi),  32'd2);
    chk("dead_mid", 32'(nm),  32'd4);
    run = 1'b0; tick();
`endif

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        set_cfg($urandom_range(0, 12), $urandom_range(0, 14),
                $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 5));
        cfg_bus.Cfg_Load = 1'b1;
      end else if (r < 7) begin
        run = ~run;
      end else if (r == 7) begin
        rst = 1'b1;
        run = 1'b0;
      end
      tick();
      cfg_bus.Cfg_Load = 1'b0;
      rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
